// File: rtl/reg_bank_pkg.sv
// Shared defaults and named register indices for the multi-port register bank.
package reg_bank_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 17;
  localparam int SP_IDX   = 16;
  localparam int SP_RESET = 1023;

  localparam int ZERO = 0;
  localparam int RET  = 16;

  // Register 0 is hard-wired and indices past the array are not backed by storage.
  function automatic logic addr_legal(input int addr, input int num_regs);
    return (addr != ZERO) && (addr < num_regs);
  endfunction
endpackage

// File: rtl/reg_bank_mp_if.sv
// Decode/writeback side of the register bank: read ports, write ports, load claims and busy flags.
interface reg_bank_mp_if #(
  parameter int DATA_W = reg_bank_pkg::DATA_W,
  parameter int ADDR_W = reg_bank_pkg::ADDR_W
);
  logic        [ADDR_W-1:0] rs;
  logic        [ADDR_W-1:0] rt;
  logic signed [DATA_W-1:0] rdData1;
  logic signed [DATA_W-1:0] rdData2;
  logic                     wrEn0;
  logic        [ADDR_W-1:0] wrAddr0;
  logic signed [DATA_W-1:0] wrData0;
  logic                     wrEn1;
  logic        [ADDR_W-1:0] wrAddr1;
  logic signed [DATA_W-1:0] wrData1;
  logic                     claimEn;
  logic        [ADDR_W-1:0] claimAddr;
  logic                     busy1;
  logic                     busy2;

  // No handshake: reads and busy lookups are combinational, writes and claims commit on the clock edge.
  modport master (
    output rs, rt, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1, claimEn, claimAddr,
    input  rdData1, rdData2, busy1, busy2
  );
  modport slave (
    input  rs, rt, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1, claimEn, claimAddr,
    output rdData1, rdData2, busy1, busy2
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-load bits: set by a load claim, cleared by load writeback, set wins on a same-address tie.
module reg_scoreboard #(
  parameter int NUM_REGS = reg_bank_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_bank_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2
);
  import reg_bank_pkg::*;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Address compares against each index keep out-of-range addresses from touching any bit.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_en && clr_addr == ADDR_W'(i)) pending_nxt[i] = 1'b0;
      if (claim_en && i != ZERO && claim_addr == ADDR_W'(i)) pending_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr1 == ADDR_W'(i)) busy1 = pending[i];
      if (rd_addr2 == ADDR_W'(i)) busy2 = pending[i];
    end
  end
endmodule

// File: rtl/reg_bank_mp.sv
// Two-read/two-write register bank with r0 hard-wired to zero, optional write bypass and load scoreboard.
module reg_bank_mp #(
  parameter int                          DATA_W   = reg_bank_pkg::DATA_W,
  parameter int                          NUM_REGS = reg_bank_pkg::NUM_REGS,
  parameter int                          ADDR_W   = reg_bank_pkg::ADDR_W,
  parameter int                          SP_IDX   = reg_bank_pkg::RET,
  parameter logic [DATA_W-1:0]           SP_RESET = DATA_W'(reg_bank_pkg::SP_RESET),
  parameter int                          BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  reg_bank_mp_if.slave bus
);
  import reg_bank_pkg::*;

  // Register 0 has no storage; reads of it fall through to the zero default.
  logic        [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic signed [DATA_W-1:0] rd1;
  logic signed [DATA_W-1:0] rd2;
  logic                     busy1_raw;
  logic                     busy2_raw;

  // While reset is held, writes are neither stored nor forwarded.
  assign wr0_ok = !rst && bus.wrEn0 && addr_legal(int'(bus.wrAddr0), NUM_REGS);
  assign wr1_ok = !rst && bus.wrEn1 && addr_legal(int'(bus.wrAddr1), NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr1_ok && bus.wrAddr1 == ADDR_W'(i))      regs[i] <= bus.wrData1;
        else if (wr0_ok && bus.wrAddr0 == ADDR_W'(i)) regs[i] <= bus.wrData0;
      end
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.rs == ADDR_W'(i)) rd1 = regs[i];
      if (bus.rt == ADDR_W'(i)) rd2 = regs[i];
    end
    // Load writeback is applied last so it overrides the ALU port, matching the collision rule.
    if (BYPASS != 0) begin
      if (wr0_ok && bus.wrAddr0 == bus.rs) rd1 = bus.wrData0;
      if (wr0_ok && bus.wrAddr0 == bus.rt) rd2 = bus.wrData0;
      if (wr1_ok && bus.wrAddr1 == bus.rs) rd1 = bus.wrData1;
      if (wr1_ok && bus.wrAddr1 == bus.rt) rd2 = bus.wrData1;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .claim_en   (bus.claimEn),
    .claim_addr (bus.claimAddr),
    .clr_en     (bus.wrEn1),
    .clr_addr   (bus.wrAddr1),
    .rd_addr1   (bus.rs),
    .rd_addr2   (bus.rt),
    .busy1      (busy1_raw),
    .busy2      (busy2_raw)
  );

  assign bus.rdData1 = rd1;
  assign bus.rdData2 = rd2;
  // A load landing this cycle is being forwarded, so the consumer need not stall.
  assign bus.busy1 = busy1_raw && !((BYPASS != 0) && wr1_ok && bus.wrAddr1 == bus.rs);
  assign bus.busy2 = busy2_raw && !((BYPASS != 0) && wr1_ok && bus.wrAddr1 == bus.rt);
endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus, a monitor checks both.
module tb_reg_bank_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 2 * DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_bank_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
  reg_bank_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

  assign bus_n.rs        = bus_b.rs;
  assign bus_n.rt        = bus_b.rt;
  assign bus_n.wrEn0     = bus_b.wrEn0;
  assign bus_n.wrAddr0   = bus_b.wrAddr0;
  assign bus_n.wrData0   = bus_b.wrData0;
  assign bus_n.wrEn1     = bus_b.wrEn1;
  assign bus_n.wrAddr1   = bus_b.wrAddr1;
  assign bus_n.wrData1   = bus_b.wrData1;
  assign bus_n.claimEn   = bus_b.claimEn;
  assign bus_n.claimAddr = bus_b.claimAddr;

  reg_bank_mp #(.BYPASS(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  reg_bank_mp #(.BYPASS(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  // Scoreboard: each entry is {rdData1, rdData2, busy1, busy2} for one instance.
  logic [IW-1:0] exp_q[$];
  logic          sel_q[$];
  string         name_q[$];
  int            pushed = 0;
  int            popped = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic drive(input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic ce, input logic [AW-1:0] ca,
                       input logic [AW-1:0] r_s, input logic [AW-1:0] r_t);
    bus_b.wrEn0 = we0; bus_b.wrAddr0 = a0; bus_b.wrData0 = d0;
    bus_b.wrEn1 = we1; bus_b.wrAddr1 = a1; bus_b.wrData1 = d1;
    bus_b.claimEn = ce; bus_b.claimAddr = ca;
    bus_b.rs = r_s; bus_b.rt = r_t;
  endtask

  task automatic reads(input logic [AW-1:0] r_s, input logic [AW-1:0] r_t);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, r_s, r_t);
  endtask

  task automatic push(input string nm, input logic sel, input logic [DW-1:0] e1,
                      input logic [DW-1:0] e2, input logic eb1, input logic eb2);
    exp_q.push_back({e1, e2, eb1, eb2});
    sel_q.push_back(sel);
    name_q.push_back(nm);
    pushed++;
  endtask

  task automatic check(input string nm,
                       input logic [DW-1:0] b1, input logic [DW-1:0] b2, input logic bb1, input logic bb2,
                       input logic [DW-1:0] n1, input logic [DW-1:0] n2, input logic nb1, input logic nb2);
    push({nm, "/byp"}, 1'b1, b1, b2, bb1, bb2);
    push({nm, "/nobyp"}, 1'b0, n1, n2, nb1, nb2);
    for (int k = 0; k < 4 && popped != pushed; k++) #1;
    if (popped != pushed) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s monitor_timeout: popped %0d required %0d", nm, popped, pushed);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [IW-1:0] act;
    forever begin
      wait (pushed != popped);
      #1;
      if (sel_q[0]) act = {bus_b.rdData1, bus_b.rdData2, bus_b.busy1, bus_b.busy2};
      else          act = {bus_n.rdData1, bus_n.rdData2, bus_n.busy1, bus_n.busy2};
      n_tests++;
      if (act !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s: got rd1=%h rd2=%h busy=%b%b required rd1=%h rd2=%h busy=%b%b",
                 name_q[0], act[IW-1 -: DW], act[DW+1 -: DW], act[1], act[0],
                 exp_q[0][IW-1 -: DW], exp_q[0][DW+1 -: DW], exp_q[0][1], exp_q[0][0]);
      end
      void'(exp_q.pop_front());
      void'(sel_q.pop_front());
      void'(name_q.pop_front());
      popped++;
    end
  end

  initial begin : stimulus
    reads(16, 5);
    #2 rst = 1'b1;
    check("reset_vals", 1023, 0, 0, 0, 1023, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    drive(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    check("r0_write_same", 0, 0, 0, 0, 0, 0, 0, 0);
    step; reads(0, 16);
    check("r0_after", 0, 1023, 0, 0, 0, 1023, 0, 0);

    drive(1, 20, 32'h1234, 1, 25, 32'h5678, 0, 0, 20, 25);
    check("oor_same", 0, 0, 0, 0, 0, 0, 0, 0);
    step; reads(20, 16);
    check("oor_after", 0, 1023, 0, 0, 0, 1023, 0, 0);

    drive(1, 3, 11, 1, 3, 22, 0, 0, 3, 3);
    check("collide_same", 22, 22, 0, 0, 0, 0, 0, 0);
    step; reads(3, 3);
    check("collide_after", 22, 22, 0, 0, 22, 22, 0, 0);

    drive(1, 4, 32'h55, 0, 0, 0, 0, 0, 4, 3);
    check("bypass_same", 32'h55, 22, 0, 0, 0, 22, 0, 0);
    step; reads(4, 3);
    check("bypass_after", 32'h55, 22, 0, 0, 32'h55, 22, 0, 0);

    drive(1, 5, 32'h66, 1, 6, 32'h77, 0, 0, 5, 6);
    check("two_ports_same", 32'h66, 32'h77, 0, 0, 0, 0, 0, 0);
    step; reads(5, 6);
    check("two_ports_after", 32'h66, 32'h77, 0, 0, 32'h66, 32'h77, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
    check("claim_same", 0, 0, 0, 0, 0, 0, 0, 0);
    step; reads(7, 7);
    check("claim_busy", 0, 0, 1, 1, 0, 0, 1, 1);

    drive(0, 0, 0, 1, 7, 32'h99, 0, 0, 7, 7);
    check("load_same", 32'h99, 32'h99, 0, 0, 0, 0, 1, 1);
    step; reads(7, 7);
    check("load_after", 32'h99, 32'h99, 0, 0, 32'h99, 32'h99, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
    step;
    drive(0, 0, 0, 1, 7, 32'hAA, 1, 7, 7, 7);
    check("set_clr_same", 32'hAA, 32'hAA, 0, 0, 32'h99, 32'h99, 1, 1);
    step; reads(7, 7);
    check("set_clr_after", 32'hAA, 32'hAA, 1, 1, 32'hAA, 32'hAA, 1, 1);

    drive(1, 7, 32'hBB, 0, 0, 0, 0, 0, 7, 3);
    check("alu_noclr_same", 32'hBB, 22, 1, 0, 32'hAA, 22, 1, 0);
    step; reads(7, 3);
    check("alu_noclr_after", 32'hBB, 22, 1, 0, 32'hBB, 22, 1, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 20);
    step;
    drive(0, 0, 0, 0, 0, 0, 1, 20, 0, 20);
    step; reads(0, 20);
    check("claim_illegal", 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 1, 16, 32'hFFFF_FFFF, 0, 0, 16, 7);
    check("sp_neg_same", 32'hFFFF_FFFF, 32'hBB, 0, 1, 1023, 32'hBB, 0, 1);
    step; reads(16, 7);
    check("sp_neg_after", 32'hFFFF_FFFF, 32'hBB, 0, 1, 32'hFFFF_FFFF, 32'hBB, 0, 1);

    drive(1, 3, 32'h33, 0, 0, 0, 1, 9, 3, 7);
    #2 rst = 1'b1;
    check("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 3, 32'h33, 0, 0, 0, 1, 9, 16, 9);
    check("rst_sp", 1023, 0, 0, 0, 1023, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    reads(3, 9);
    check("rst_discard", 0, 0, 0, 0, 0, 0, 0, 0);

    drive(1, 9, 5, 0, 0, 0, 1, 10, 9, 10);
    check("post_rst_same", 5, 0, 0, 0, 0, 0, 0, 0);
    step; reads(9, 10);
    check("post_rst_after", 5, 0, 0, 1, 5, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-port register bank for the pipelined datapath: two combinational read ports, two write ports (ALU writeback and load writeback), an optional same-cycle write-to-read bypass and a per-register pending-load scoreboard. Register 0 is hard-wired to zero. A configurable special register (RET/stack pointer) resets to a programmable value. The block sits between decode (reads, busy checks, load claims) and writeback (writes).

## Interface
- DATA_W, 32, register width (signed data)
- NUM_REGS, 17, implemented registers, indices 0..NUM_REGS-1
- ADDR_W, 5, register address width; 2**ADDR_W >= NUM_REGS
- SP_IDX, 16, index of the special register
- SP_RESET, 1023, reset value of register SP_IDX
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see the array only
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- rs  in  ADDR_W  read address, port 1
- rt  in  ADDR_W  read address, port 2
- rdData1  out  DATA_W  signed read data, port 1
- rdData2  out  DATA_W  signed read data, port 2
- wrEn0  in  1  ALU writeback enable
- wrAddr0  in  ADDR_W  ALU writeback address
- wrData0  in  DATA_W  ALU writeback data
- wrEn1  in  1  load writeback enable; also clears the pending bit
- wrAddr1  in  ADDR_W  load writeback address
- wrData1  in  DATA_W  load writeback data
- claimEn  in  1  a load to claimAddr has issued
- claimAddr  in  ADDR_W  destination of the issued load
- busy1  out  1  rs has a pending load
- busy2  out  1  rt has a pending load

## Operation
- Reset (async, while rst=1): all registers 0, register SP_IDX = SP_RESET, all pending bits 0. Outputs follow combinationally: rdData* = array value (0 or SP_RESET), busy* = 0.
- Write: on rising clk with rst=0, wrEnN=1 writes wrDataN to wrAddrN.
- Ignored writes: address 0 and addresses >= NUM_REGS.
- Write collision: both ports enabled to the same address means port 1 (load) wins.
- Read: rdDataN = 0 if address is 0 or >= NUM_REGS; otherwise the register value.
- Bypass, BYPASS=1: a read whose address matches an enabled, legal write in the same cycle returns that write's data. Port 1 takes priority over port 0.
- Bypass, BYPASS=0: no forwarding; new data is visible the cycle after the edge.
- Scoreboard, set: claimEn=1 with a legal, nonzero claimAddr sets pending[claimAddr] at the edge.
- Scoreboard, clear: wrEn1=1 with a legal address clears pending[wrAddr1] at the edge. wrEn0 never clears.
- Scoreboard, simultaneous set and clear on the same address: set wins, because a new load is outstanding.
- busyN = pending[addr] && addr != 0 && addr < NUM_REGS.
- Busy suppression, BYPASS=1 only: busyN is forced to 0 when wrEn1 targets the same address in that cycle, because the data is being forwarded.

## Timing
- Read latency 0; write latency 1 edge.
- Scoreboard update latency 1 edge; busy reflects the claim from the cycle after claimEn.
- rst asserted mid-cycle clears the state immediately, independent of clk. Writes and claims presented during reset are discarded.
- After rst deasserts, the first edge performs normal writes and claims.

## Structure
- Package reg_bank_pkg holds the defaults DATA_W, ADDR_W, NUM_REGS, SP_IDX, SP_RESET and named constants for register indices (ZERO=0, RET=16).
- Sub-module reg_scoreboard holds the pending-bit vector with its set/clear/priority logic and the two busy lookups. It is parametrised by NUM_REGS and ADDR_W, with clk/rst shared.
- The top level holds the register array, the write-collision logic and the bypass muxes.

## Test plan
- Reset value: pulse rst mid-cycle -> rdData1 for rs=16 reads 1023; rs=5 reads 0; busy1=busy2=0 with no clock edge required.
- Zero register and range checks:
  - wrEn0 with wrAddr0=0, wrData0=0xDEAD, then rs=0 -> 0.
  - wrAddr0=20 (NUM_REGS=17) -> no register changes; rs=20 reads 0.
- Collision: wrEn0 and wrEn1 both to r3, data 11 and 22 -> after the edge r3=22.
- Bypass:
  - BYPASS=1: wrEn0 to r4 with 0x55 and rs=4 in the same cycle -> rdData1=0x55 before the edge.
  - BYPASS=0: the same stimulus -> old value before the edge, 0x55 after.
- Scoreboard:
  - claimEn on r7, then rs=7 -> busy1=1 the next cycle.
  - wrEn1 to r7 -> busy1=0 in the same cycle (BYPASS=1), pending cleared after the edge.
  - Simultaneous claim and wrEn1 on r7 -> pending stays 1.
- Reset mid-operation: pending r7 and r3=22, assert rst -> busy1=0, r3=0, r16=1023 immediately.
